// File: rtl/ps2_host_fifo.sv
// PS/2 host: filtered receiver, RX FIFO, Avalon-MM slave (read latency 1).
// Define PS2_TX_EN to build the host-to-device transmitter and line drivers.
module ps2_host_fifo #(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int INHIBIT_CYCLES = 5000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    inout  wire         ps2_clk_export,
    inout  wire         ps2_data_export
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int FW   = $clog2(FILTER_LEN + 1);
    localparam int TMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                          TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          filt_clk, filt_flip, fall;
    logic [FW-1:0] filt_cnt;

    logic          irq_en, rx_enable, err_irq_en;
    logic          perr, ovf, tx_err, ferr;
    logic          tx_busy, set_txerr;
    logic          unused_wd;

    assign unused_wd = ^avs_writedata;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_export};
            dat_sync <= {dat_sync[0], ps2_data_export};
        end
    end

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // The filtered clock flips only after FILTER_LEN samples disagree with it.
    assign filt_flip = (clk_s != filt_clk) &&
                       (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall      = filt_flip && filt_clk;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt_clk <= ~filt_clk;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    typedef enum logic [1:0] {
        RX_IDLE, RX_SHIFT, RX_PARITY, RX_STOP
    } rx_state_t;

    rx_state_t     rx_state, rx_nxt;
    logic [7:0]    rx_sh, rx_sh_nxt;
    logic [2:0]    rx_cnt, rx_cnt_nxt;
    logic          rx_par, rx_par_nxt;
    logic [TW-1:0] rx_tmr, rx_tmr_nxt;
    logic          rx_push, set_perr, set_ferr;

    always_comb begin
        rx_nxt     = rx_state;
        rx_sh_nxt  = rx_sh;
        rx_cnt_nxt = rx_cnt;
        rx_par_nxt = rx_par;
        rx_push    = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        rx_tmr_nxt = (rx_state == RX_IDLE || fall) ? '0 : rx_tmr + 1'b1;
        unique case (rx_state)
            RX_IDLE: begin
                if (fall && !dat_s && rx_enable && !tx_busy) begin
                    rx_nxt     = RX_SHIFT;
                    rx_cnt_nxt = '0;
                end
            end
            RX_SHIFT: begin
                if (fall) begin
                    rx_sh_nxt  = {dat_s, rx_sh[7:1]};
                    rx_cnt_nxt = rx_cnt + 1'b1;
                    if (rx_cnt == 3'd7) rx_nxt = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (fall) begin
                    rx_par_nxt = dat_s;
                    rx_nxt     = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    rx_nxt   = RX_IDLE;
                    set_perr = ~^{rx_sh, rx_par};
                    set_ferr = ~dat_s;
                    rx_push  = dat_s && (^{rx_sh, rx_par});
                end
            end
            default: rx_nxt = RX_IDLE;
        endcase
        if (rx_state != RX_IDLE && !fall &&
            rx_tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            rx_nxt   = RX_IDLE;
            set_ferr = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rx_state <= RX_IDLE;
            rx_sh    <= '0;
            rx_cnt   <= '0;
            rx_par   <= 1'b0;
            rx_tmr   <= '0;
        end else begin
            rx_state <= rx_nxt;
            rx_sh    <= rx_sh_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_par   <= rx_par_nxt;
            rx_tmr   <= rx_tmr_nxt;
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          not_empty, full, pop, push, set_ovf;
    logic          rd_data, wr_status, wr_ctrl;

    assign rd_data   = avs_read && avs_address == 2'd0;
    assign wr_status = avs_write && avs_address == 2'd1;
    assign wr_ctrl   = avs_write && avs_address == 2'd2;
    assign not_empty = |count;
    assign full      = count == CW'(FIFO_DEPTH);
    assign pop       = rd_data && not_empty;
    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    assign push      = rx_push && (!full || pop);
    assign set_ovf   = rx_push && full && !pop;

    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr] <= rx_sh;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_en     <= 1'b0;
            rx_enable  <= 1'b1;
            err_irq_en <= 1'b0;
            perr       <= 1'b0;
            ovf        <= 1'b0;
            tx_err     <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en     <= avs_writedata[0];
                rx_enable  <= avs_writedata[1];
                err_irq_en <= avs_writedata[2];
            end
            perr   <= set_perr  | (perr   & ~(wr_status & avs_writedata[2]));
            ovf    <= set_ovf   | (ovf    & ~(wr_status & avs_writedata[3]));
            tx_err <= set_txerr | (tx_err & ~(wr_status & avs_writedata[4]));
            ferr   <= set_ferr  | (ferr   & ~(wr_status & avs_writedata[5]));
        end
    end

    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            2'd0: if (not_empty)
                rd_mux = {8'd0, 8'(count), 1'b1, 7'd0, mem[rd_ptr]};
            2'd1: rd_mux = {26'd0, ferr, tx_err, ovf, perr,
                            tx_busy, not_empty};
            2'd2: rd_mux = {29'd0, err_irq_en, rx_enable, irq_en};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (avs_read) avs_readdata <= rd_mux;
            irq <= (irq_en & not_empty) |
                   (err_irq_en & (perr | ovf | tx_err | ferr));
        end
    end

`ifdef PS2_TX_EN
    typedef enum logic [2:0] {
        TX_IDLE, TX_PEND, TX_INHIBIT, TX_START,
        TX_SHIFT, TX_STOP, TX_ACK, TX_WAIT
    } tx_state_t;

    tx_state_t     tx_state, tx_nxt;
    logic [8:0]    tx_sh, tx_sh_nxt;
    logic [3:0]    tx_cnt, tx_cnt_nxt;
    logic [TW-1:0] tx_tmr, tx_tmr_nxt;
    logic          clk_low, clk_low_nxt, dat_low, dat_low_nxt;
    logic          tx_req, rx_idle;

    assign tx_req  = avs_write && avs_address == 2'd0;
    assign rx_idle = rx_state == RX_IDLE;
    assign tx_busy = tx_state != TX_IDLE;

    always_comb begin
        tx_nxt      = tx_state;
        tx_sh_nxt   = tx_sh;
        tx_cnt_nxt  = tx_cnt;
        clk_low_nxt = clk_low;
        dat_low_nxt = dat_low;
        tx_tmr_nxt  = tx_tmr + 1'b1;
        set_txerr   = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_tmr_nxt = '0;
                if (tx_req) begin
                    tx_sh_nxt   = {~^avs_writedata[7:0], avs_writedata[7:0]};
                    tx_nxt      = rx_idle ? TX_INHIBIT : TX_PEND;
                    clk_low_nxt = rx_idle;
                end
            end
            TX_PEND: begin
                tx_tmr_nxt = '0;
                if (rx_idle) begin
                    tx_nxt      = TX_INHIBIT;
                    clk_low_nxt = 1'b1;
                end
            end
            TX_INHIBIT: begin
                if (tx_tmr == TW'(INHIBIT_CYCLES - 1)) begin
                    tx_nxt      = TX_START;
                    clk_low_nxt = 1'b0;
                    dat_low_nxt = 1'b1;
                    tx_tmr_nxt  = '0;
                end
            end
            TX_START: begin
                if (fall) begin
                    dat_low_nxt = ~tx_sh[0];
                    tx_cnt_nxt  = 4'd1;
                    tx_nxt      = TX_SHIFT;
                    tx_tmr_nxt  = '0;
                end
            end
            TX_SHIFT: begin
                if (fall) begin
                    dat_low_nxt = ~tx_sh[tx_cnt];
                    tx_cnt_nxt  = tx_cnt + 1'b1;
                    tx_tmr_nxt  = '0;
                    if (tx_cnt == 4'd8) tx_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (fall) begin
                    dat_low_nxt = 1'b0;
                    tx_nxt      = TX_ACK;
                    tx_tmr_nxt  = '0;
                end
            end
            TX_ACK: begin
                if (fall) begin
                    set_txerr  = dat_s;
                    tx_nxt     = dat_s ? TX_IDLE : TX_WAIT;
                    tx_tmr_nxt = '0;
                end
            end
            TX_WAIT: begin
                if (filt_clk && dat_s) tx_nxt = TX_IDLE;
            end
            default: tx_nxt = TX_IDLE;
        endcase
        // A silent device during the frame abandons it and frees both lines.
        if (tx_state inside {TX_START, TX_SHIFT, TX_STOP, TX_ACK, TX_WAIT} &&
            tx_nxt == tx_state && !fall &&
            tx_tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            tx_nxt      = TX_IDLE;
            set_txerr   = 1'b1;
            clk_low_nxt = 1'b0;
            dat_low_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '0;
            tx_cnt   <= '0;
            tx_tmr   <= '0;
            clk_low  <= 1'b0;
            dat_low  <= 1'b0;
        end else begin
            tx_state <= tx_nxt;
            tx_sh    <= tx_sh_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_tmr   <= tx_tmr_nxt;
            clk_low  <= clk_low_nxt;
            dat_low  <= dat_low_nxt;
        end
    end

    assign ps2_clk_export  = clk_low ? 1'b0 : 1'bz;
    assign ps2_data_export = dat_low ? 1'b0 : 1'bz;
`else
    assign tx_busy         = 1'b0;
    assign set_txerr       = 1'b0;
    assign ps2_clk_export  = 1'bz;
    assign ps2_data_export = 1'bz;
`endif

endmodule
